// File: rtl/led_column_scanner_if.sv
// Host-side bundle for led_column_scanner: buffer write port, playback control and LED column outputs.
interface led_column_scanner_if #(
   parameter int ROWS  = 5,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [ROWS-1:0] wr_data;
   logic [AW:0]     len;
   logic            start;
   logic            stop;
   logic            loop;
   logic [ROWS-1:0] col_out;
   logic [AW-1:0]   col_idx;
   logic            col_strobe;
   logic            busy;
   logic            done;

   modport master (
      output wr_en, wr_addr, wr_data, len, start, stop, loop,
      input  col_out, col_idx, col_strobe, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, len, start, stop, loop,
      output col_out, col_idx, col_strobe, busy, done
   );
endinterface

// File: rtl/led_column_scanner.sv
// Column-scan LED banner engine: first column 1 clock after start, each column held COL_CYCLES clocks; no backpressure.
// Looping playback is only built when LED_COLUMN_SCANNER_LOOP_EN is defined; otherwise every frame is one-shot.
module led_column_scanner #(
   parameter int ROWS       = 5,
   parameter int DEPTH      = 64,
   parameter int COL_CYCLES = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   led_column_scanner_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
   localparam logic [AW:0]   LEN_MAX    = (AW+1)'(DEPTH);
   localparam logic [DW-1:0] DWELL_LAST = DW'(COL_CYCLES - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t          state;
   logic [ROWS-1:0] mem [DEPTH];
   logic [AW:0]     len_q;
   logic [DW-1:0]   dwell;
   logic [ROWS-1:0] col_out;
   logic [AW-1:0]   col_idx;
   logic            col_strobe;
   logic            busy;
   logic            done;
   logic [AW-1:0]   next_idx;
   logic            last_col;
`ifdef LED_COLUMN_SCANNER_LOOP_EN
   logic            loop_q;
`endif

   assign next_idx = col_idx + 1'b1;
   assign last_col = ({1'b0, col_idx} == (len_q - 1'b1));

   assign bus.col_out    = col_out;
   assign bus.col_idx    = col_idx;
   assign bus.col_strobe = col_strobe;
   assign bus.busy       = busy;
   assign bus.done       = done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Fetches read mem before this edge's write lands, so a write racing a fetch is seen next time round.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         len_q      <= '0;
         dwell      <= '0;
         col_out    <= '0;
         col_idx    <= '0;
         col_strobe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef LED_COLUMN_SCANNER_LOOP_EN
         loop_q     <= 1'b0;
`endif
      end else begin
         col_strobe <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && (bus.len != '0)) begin
                  len_q      <= (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
`ifdef LED_COLUMN_SCANNER_LOOP_EN
                  loop_q     <= bus.loop;
`endif
                  col_out    <= mem[0];
                  col_idx    <= '0;
                  col_strobe <= 1'b1;
                  dwell      <= '0;
                  busy       <= 1'b1;
                  state      <= SHOW;
               end
            end
            SHOW: begin
               if (bus.stop) begin
                  col_out <= '0;
                  col_idx <= '0;
                  dwell   <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (dwell != DWELL_LAST) begin
                  dwell <= dwell + 1'b1;
               end else if (!last_col) begin
                  col_idx    <= next_idx;
                  col_out    <= mem[next_idx];
                  col_strobe <= 1'b1;
                  dwell      <= '0;
`ifdef LED_COLUMN_SCANNER_LOOP_EN
               end else if (loop_q) begin
                  col_idx    <= '0;
                  col_out    <= mem[0];
                  col_strobe <= 1'b1;
                  done       <= 1'b1;
                  dwell      <= '0;
`endif
               end else begin
                  col_out <= '0;
                  col_idx <= '0;
                  dwell   <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_led_column_scanner.sv
// Directed bench for led_column_scanner; a strobe-driven scoreboard checks every column fetch.
module tb_led_column_scanner;
   localparam int ROWS       = 5;
   localparam int DEPTH      = 64;
   localparam int COL_CYCLES = 5;
   localparam int AW         = $clog2(DEPTH);

   typedef struct packed {
      logic [AW-1:0]   idx;
      logic [ROWS-1:0] col;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];
   logic [ROWS-1:0] msg [5];

   led_column_scanner_if #(.ROWS(ROWS), .DEPTH(DEPTH)) bus ();

   led_column_scanner #(.ROWS(ROWS), .DEPTH(DEPTH), .COL_CYCLES(COL_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input logic [ROWS-1:0] col);
      exp_t e;
      e.idx = AW'(idx);
      e.col = col;
      sb.push_back(e);
   endtask

   task automatic wr(input int addr, input logic [ROWS-1:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < limit) begin
         step();
         cycles++;
      end
      chk("done_timeout", {31'd0, bus.done}, 32'd1);
   endtask

   function automatic logic [ROWS-1:0] pat_of(input int i);
      return ROWS'((i * 7 + 3) % 32);
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_col"},    32'(bus.col_out),    32'd0);
      chk({tag, "_idx"},    32'(bus.col_idx),    32'd0);
      chk({tag, "_strobe"}, 32'(bus.col_strobe), 32'd0);
      chk({tag, "_busy"},   32'(bus.busy),       32'd0);
      chk({tag, "_done"},   32'(bus.done),       32'd0);
   endtask

   // Each column fetch must match the next expected {idx, col}.
   always @(negedge clk) begin
      if (bus.col_strobe === 1'b1) begin
         chk("sb_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_col", 32'(bus.col_out), 32'(e.col));
            chk("sb_idx", 32'(bus.col_idx), 32'(e.idx));
         end
      end
   end

   initial begin
      int cyc;
      msg[0] = 5'h1F; msg[1] = 5'h14; msg[2] = 5'h14; msg[3] = 5'h1C; msg[4] = 5'h00;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.len = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
      step(); step();
      chk_idle("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) wr(i, msg[i]);

      // One-shot frame with per-cycle timing.
      for (int i = 0; i < 5; i++) push(i, msg[i]);
      bus.len = 7'd5; bus.loop = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         chk("a_col",  32'(bus.col_out), 32'(msg[(c - 1) / COL_CYCLES]));
         chk("a_busy", 32'(bus.busy), 32'd1);
         chk("a_done", 32'(bus.done), 32'd0);
         step();
      end
      chk("a_end_done", 32'(bus.done), 32'd1);
      chk("a_end_busy", 32'(bus.busy), 32'd0);
      chk("a_end_col",  32'(bus.col_out), 32'd0);
      chk("a_end_idx",  32'(bus.col_idx), 32'd0);

      // Loop request, with a write to the column being shown.
      for (int i = 0; i < 5; i++) push(i, msg[i]);
      bus.loop = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (11) step();
      bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = 5'h0A;
      step();
      bus.wr_en = 1'b0; bus.loop = 1'b0;
      for (int c = 13; c <= 15; c++) begin
         chk("b_wr_hold", 32'(bus.col_out), 32'h14);
         step();
      end
      repeat (10) step();
`ifdef LED_COLUMN_SCANNER_LOOP_EN
      for (int i = 0; i < 5; i++) push(i, (i == 2) ? 5'h0A : msg[i]);
      for (int i = 0; i < 3; i++) push(i, (i == 2) ? 5'h0A : msg[i]);
      chk("b_loop_done1", 32'(bus.done), 32'd1);
      chk("b_loop_strb1", 32'(bus.col_strobe), 32'd1);
      chk("b_loop_col1",  32'(bus.col_out), 32'h1F);
      chk("b_loop_busy1", 32'(bus.busy), 32'd1);
      repeat (25) step();
      chk("b_loop_done2", 32'(bus.done), 32'd1);
      chk("b_loop_col2",  32'(bus.col_out), 32'h1F);
      chk("b_loop_busy2", 32'(bus.busy), 32'd1);
      repeat (10) step();
`else
      chk("b_once_done", 32'(bus.done), 32'd1);
      chk("b_once_busy", 32'(bus.busy), 32'd0);
      chk("b_once_col",  32'(bus.col_out), 32'd0);
      for (int i = 0; i < 3; i++) push(i, (i == 2) ? 5'h0A : msg[i]);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (10) step();
`endif
      // Stop during the third column.
      chk("b_third_col", 32'(bus.col_out), 32'h0A);
      chk("b_third_idx", 32'(bus.col_idx), 32'd2);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk_idle("b_stop");
      step();
      chk_idle("b_stop_after");

      // Zero-length start is ignored.
      bus.len = '0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_idle("c_len0");
      step();
      chk_idle("c_len0_after");

      // Oversize length plays the whole buffer; write to 0 racing start is not seen.
      for (int i = 1; i < DEPTH; i++) wr(i, pat_of(i));
      push(0, 5'h1F);
      for (int i = 1; i < DEPTH; i++) push(i, pat_of(i));
      bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 5'h11;
      bus.len = 7'(DEPTH + 1); bus.start = 1'b1;
      step();
      bus.wr_en = 1'b0; bus.start = 1'b0;
      chk("c_first_col", 32'(bus.col_out), 32'h1F);
      chk("c_first_busy", 32'(bus.busy), 32'd1);
      wait_done(400, cyc);
      chk("c_frame_len", 32'(cyc), 32'(DEPTH * COL_CYCLES));
      chk("c_end_busy", 32'(bus.busy), 32'd0);

      // Reset mid-column clears outputs and buffer.
      push(0, 5'h11);
      push(1, pat_of(1));
      bus.len = 7'd5; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (6) step();
      chk("d_pre_col", 32'(bus.col_out), 32'(pat_of(1)));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_idle("d_reset");
      for (int i = 0; i < 5; i++) push(i, 5'h00);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("d_replay_busy", 32'(bus.busy), 32'd1);
      wait_done(40, cyc);
      chk("d_replay_len", 32'(cyc), 32'(5 * COL_CYCLES));

      step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
